// File: rtl/prod_accumulator.sv
// Multiply-accumulate back end: sums groups of unsigned products behind valid/ready ports.
// Define PROD_ACC_SAT_EN to clamp the sum at all-ones on carry-out (default build wraps).
module prod_accumulator #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 72,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  acc_count,
   output logic              overflow
);

`ifdef PROD_ACC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic               vld_p0;
   logic [ACC_W:0]     sum_p0;

   logic [ACC_W-1:0]   acc_p1;
   logic [CNT_W-1:0]   cnt_p1;
   logic               ovf_p1;
   logic               vld_p1;

   // One extra bit catches the carry-out of the running sum.
   function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
      return {1'b0, a} + (ACC_W+1)'(b);
   endfunction

   function automatic logic [ACC_W-1:0] sat_or_wrap(input logic [ACC_W:0] s);
      return (SAT_EN && s[ACC_W]) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   // Stage p0: beat acceptance and the wide add
   assign vld_p0 = in_valid && in_ready;
   assign sum_p0 = add_wide(acc_p1, prod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (vld_p0) state_d = in_last ? HOLD : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (vld_p0 && in_last) state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   // Stage p1: accumulator and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p1 <= '0;
         cnt_p1 <= '0;
         ovf_p1 <= 1'b0;
         vld_p1 <= 1'b0;
      end else if (clear) begin
         acc_p1 <= '0;
         cnt_p1 <= '0;
         ovf_p1 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= (state_d == HOLD);
         if (vld_p0) begin
            if (state_q == IDLE) begin
               acc_p1 <= ACC_W'(prod);
               cnt_p1 <= {{(CNT_W-1){1'b0}}, 1'b1};
               ovf_p1 <= 1'b0;
            end else begin
               acc_p1 <= sat_or_wrap(sum_p0);
               cnt_p1 <= cnt_sat_inc(cnt_p1);
               ovf_p1 <= ovf_p1 | sum_p0[ACC_W];
            end
         end
      end
   end

   assign out_valid = vld_p1;
   assign acc_out   = acc_p1;
   assign acc_count = cnt_p1;
   assign overflow  = ovf_p1;

endmodule
